mmc_sm_insertion_selector: RTL and testbench
============================================

// Module: mmc_sm_insertion_selector
// PURPOSE
//   Converts a requested inserted-submodule count into a per-submodule gate vector for one MMC arm.
//   Sorts the capacitor voltages over several cycles with odd-even transposition.
//   It then inserts the n_on lowest-voltage cells when the arm current charges, or the n_on highest when it discharges.
//   It is the inverse of the count-threshold check: count in, insertion pattern out (popcount(gate)==min(n_on,N)).
// PARAMETERS
//   N   5   submodules per arm (>=2)
//   W   12  capacitor-voltage width, unsigned
//   CW  $clog2(N+1) (localparam) width of n_on
// PORTS
//   clk        in   1     single clock, rising edge
//   rst_n      in   1     asynchronous, active-low reset
//   req_valid  in   1     request present
//   req_ready  out  1     high only in IDLE; accept = req_valid && req_ready at a clk edge
//   n_on       in   CW    submodules to insert; sampled at accept
//   i_pos      in   1     1 = arm current charges (insert lowest V), 0 = discharges (insert highest V)
//   v_cap      in   N*W   voltages, cell i at [i*W +: W]; sampled at accept only
//   gate       out  N     bit i = 1 inserts cell i; held between updates
//   gate_valid out  1     one-cycle pulse: gate was updated from the last accepted request
//   n_err      out  1     n_on > N on that request (clamped to N); updates with gate
// BEHAVIOUR
// - Reset (async assert): state=IDLE, gate=0 (all bypassed), gate_valid=0, n_err=0, hold flag cleared.
// - Reset mid-operation: aborts the request with no gate_valid pulse.
// - FSM IDLE -> SORT -> SEL -> IDLE.
// - Accept at edge k: latch v_cap, n_on (clamped), i_pos; idx[i]=i; pass=0; -> SORT.
// - SORT, edges k+1..k+N: pass p compares pairs (j, j+1).
//   - j even when p is even, j odd when p is odd.
//   - Swap if v[a]>v[b], or v[a]==v[b] and idx[a]>idx[b].
//   - Result: ascending by voltage, ties by lower index first; fully sorted after N passes.
//   - -> SEL at edge k+N.
// - SEL, edge k+N+1: gate[idx[s]]=1 for s in 0..n-1 (i_pos=1) or s in N-n..N-1 (i_pos=0); gate_valid=1; n_err set; -> IDLE.
// - Latency: accept edge to gate_valid high = N+1 edges. gate_valid drops at the next edge.
// - req_ready is high during the gate_valid cycle, so back-to-back requests are allowed.
// - n_on=0 gives gate=0; n_on>=N gives gate=all ones; n_err=1 only if n_on>N.
// - Changes on v_cap, n_on or i_pos while busy are ignored.
// CONFIGURATION
//   BALANCE_HOLD_EN: switching-loss reduction.
//   - Defined: if an accepted request's clamped n_on and i_pos equal the last completed request's (hold flag set), SORT/SEL are skipped.
//     At edge k+1, gate is re-asserted unchanged with gate_valid=1 and n_err recomputed.
//   - Undefined: every request runs the full N+1-edge sort.
//   - The hold flag is set on every completed request and cleared by reset.
// STRUCTURE
//   Package mmc_sort_pkg: state enum (IDLE, SORT, SEL); N/W defaults; CW width function; voltage/index typedefs.
//   Sub-module mmc_cmp_swap: combinational compare-exchange on (v,idx) pairs with the tie rule above; floor(N/2) instances, muxed by pass parity.
// TESTING (N=5, W=12)
//   1 v={100,400,200,500,300} (cell0..4), n_on=2, i_pos=1 -> gate=5'b00101, gate_valid at edge k+6, n_err=0
//   2 same v, n_on=2, i_pos=0 -> gate=5'b01010 (cells 3,1)
//   3 all v=250, n_on=3: i_pos=1 -> 5'b00111; i_pos=0 -> 5'b11100 (tie order by index)
//   4 n_on=0 -> gate=0, n_err=0; n_on=7 -> gate=5'b11111, n_err=1
//   5 rst_n low during pass 2 -> gate=0, no gate_valid pulse, req_ready=1 after release; v_cap toggled mid-sort has no effect
//   6 Back-to-back request accepted in the gate_valid cycle -> next gate_valid N+1 edges later.
//     With BALANCE_HOLD_EN, a repeated n_on/i_pos -> gate_valid at edge k+1 with the gate unchanged.

Source files
------------

// File: rtl/mmc_sort_pkg.sv
// Shared types and defaults for the MMC submodule insertion selector.
// Holds the controller state enum, default arm size and voltage width,
// and the helper that sizes the inserted-count field.
package mmc_sort_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SORT = 2'd1,
      SEL  = 2'd2
   } state_e;

   localparam int N_DEF = 5;
   localparam int W_DEF = 12;

   // Width needed to hold a count from 0 to n inclusive
   function automatic int cntWidth(input int n);
      return $clog2(n + 1);
   endfunction

   typedef logic [W_DEF-1:0]          volt_t;
   typedef logic [$clog2(N_DEF)-1:0]  idx_t;

endpackage

// File: rtl/mmc_cmp_swap.sv
// Compare-exchange cell for the odd-even transposition sorter.
// Orders one (voltage, cell index) pair so the lower voltage comes out on
// the lo side; equal voltages are ordered by lower cell index first.
module mmc_cmp_swap
   import mmc_sort_pkg::*;
#(
   parameter int W  = W_DEF,
   parameter int IW = 3
) (
   input  logic [W-1:0]  aV_i,
   input  logic [IW-1:0] aIdx_i,
   input  logic [W-1:0]  bV_i,
   input  logic [IW-1:0] bIdx_i,
   output logic [W-1:0]  loV_o,
   output logic [IW-1:0] loIdx_o,
   output logic [W-1:0]  hiV_o,
   output logic [IW-1:0] hiIdx_o
);

   logic swap;

   // Exchange when a is larger, or equal with the larger index, giving a stable order
   always_comb begin
      swap = (aV_i > bV_i) || ((aV_i == bV_i) && (aIdx_i > bIdx_i));
      if (swap) begin
         loV_o   = bV_i;
         loIdx_o = bIdx_i;
         hiV_o   = aV_i;
         hiIdx_o = aIdx_i;
      end else begin
         loV_o   = aV_i;
         loIdx_o = aIdx_i;
         hiV_o   = bV_i;
         hiIdx_o = bIdx_i;
      end
   end

endmodule

// File: rtl/mmc_sm_insertion_selector.sv
// MMC arm insertion selector: turns a requested inserted-submodule count
// into a per-cell gate vector. Capacitor voltages are sorted over N cycles
// by odd-even transposition, then the n lowest (charging current) or n
// highest (discharging current) cells are inserted.
// Optional feature macro: BALANCE_HOLD_EN -- when a request repeats the last
// completed count and current direction, the sort is skipped and the
// previous gate pattern is re-issued one cycle after accept.
module mmc_sm_insertion_selector
   import mmc_sort_pkg::*;
#(
   parameter  int N  = N_DEF,
   parameter  int W  = W_DEF,
   localparam int CW = cntWidth(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [CW-1:0] n_on,
   input  logic          i_pos,
   input  logic [N*W-1:0] v_cap,
   output logic [N-1:0]  gate,
   output logic          gate_valid,
   output logic          n_err
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int NP = N / 2;

   state_e        state_q;
   logic [W-1:0]  vCap_q [N];
   logic [IW-1:0] idx_q  [N];
   logic [IW-1:0] pass_q;
   logic [CW-1:0] nOn_q;
   logic          iPos_q;
   logic          errPend_q;
   logic          skip_q;
   logic [N-1:0]  gate_q;
   logic          gateValid_q;
   logic          nErr_q;
`ifdef BALANCE_HOLD_EN
   logic          hold_q;
   logic [CW-1:0] lastN_q;
   logic          lastPos_q;
`endif

   logic [W-1:0]  sortV   [N];
   logic [IW-1:0] sortIdx [N];
   logic [N-1:0]  selGate;
   logic [CW-1:0] nClamp;
   logic          nOver;
   logic          holdHit;

   logic [W-1:0]  cmpAV [NP];
   logic [W-1:0]  cmpBV [NP];
   logic [IW-1:0] cmpAI [NP];
   logic [IW-1:0] cmpBI [NP];
   logic [W-1:0]  loV   [NP];
   logic [W-1:0]  hiV   [NP];
   logic [IW-1:0] loI   [NP];
   logic [IW-1:0] hiI   [NP];

   assign req_ready  = (state_q == IDLE);
   assign gate       = gate_q;
   assign gate_valid = gateValid_q;
   assign n_err      = nErr_q;

   // Each compare-exchange serves pair (2m,2m+1) on even passes and (2m+1,2m+2) on odd passes
   for (genvar m = 0; m < NP; m++) begin : g_cmp
      localparam int AE = 2 * m;
      if ((2 * m + 2) < N) begin : g_both
         assign cmpAV[m] = pass_q[0] ? vCap_q[AE+1] : vCap_q[AE];
         assign cmpBV[m] = pass_q[0] ? vCap_q[AE+2] : vCap_q[AE+1];
         assign cmpAI[m] = pass_q[0] ? idx_q[AE+1]  : idx_q[AE];
         assign cmpBI[m] = pass_q[0] ? idx_q[AE+2]  : idx_q[AE+1];
      end else begin : g_evenOnly
         assign cmpAV[m] = vCap_q[AE];
         assign cmpBV[m] = vCap_q[AE+1];
         assign cmpAI[m] = idx_q[AE];
         assign cmpBI[m] = idx_q[AE+1];
      end
      mmc_cmp_swap #(.W(W), .IW(IW)) u_cmp (
         .aV_i    (cmpAV[m]),
         .aIdx_i  (cmpAI[m]),
         .bV_i    (cmpBV[m]),
         .bIdx_i  (cmpBI[m]),
         .loV_o   (loV[m]),
         .loIdx_o (loI[m]),
         .hiV_o   (hiV[m]),
         .hiIdx_o (hiI[m])
      );
   end

   // One transposition pass: write exchanged pairs back, cells outside any pair stay put
   always_comb begin
      int a;
      a       = 0;
      sortV   = vCap_q;
      sortIdx = idx_q;
      for (int m = 0; m < NP; m++) begin
         a = 2 * m + int'(pass_q[0]);
         if ((a + 1) < N) begin
            sortV[a]     = loV[m];
            sortV[a+1]   = hiV[m];
            sortIdx[a]   = loI[m];
            sortIdx[a+1] = hiI[m];
         end
      end
   end

   // Insert the n bottom ranks when charging, the n top ranks when discharging
   always_comb begin
      selGate = '0;
      for (int s = 0; s < N; s++) begin
         if (iPos_q ? (s < int'(nOn_q)) : (s >= (N - int'(nOn_q)))) begin
            selGate[idx_q[s]] = 1'b1;
         end
      end
   end

   // Clamp the requested count and decide whether the previous pattern can be reused
   always_comb begin
      nOver   = (n_on > CW'(N));
      nClamp  = nOver ? CW'(N) : n_on;
`ifdef BALANCE_HOLD_EN
      holdHit = hold_q && (nClamp == lastN_q) && (i_pos == lastPos_q);
`else
      holdHit = 1'b0;
`endif
   end

   // Controller: accept, sort for N passes, select and publish the gate pattern
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pass_q      <= '0;
         nOn_q       <= '0;
         iPos_q      <= 1'b0;
         errPend_q   <= 1'b0;
         skip_q      <= 1'b0;
         gate_q      <= '0;
         gateValid_q <= 1'b0;
         nErr_q      <= 1'b0;
         for (int i = 0; i < N; i++) begin
            vCap_q[i] <= '0;
            idx_q[i]  <= '0;
         end
`ifdef BALANCE_HOLD_EN
         hold_q      <= 1'b0;
         lastN_q     <= '0;
         lastPos_q   <= 1'b0;
`endif
      end else begin
         gateValid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  for (int i = 0; i < N; i++) begin
                     vCap_q[i] <= v_cap[i*W +: W];
                     idx_q[i]  <= IW'(i);
                  end
                  nOn_q     <= nClamp;
                  iPos_q    <= i_pos;
                  errPend_q <= nOver;
                  pass_q    <= '0;
                  skip_q    <= holdHit;
                  state_q   <= holdHit ? SEL : SORT;
               end
            end
            SORT: begin
               vCap_q <= sortV;
               idx_q  <= sortIdx;
               pass_q <= pass_q + IW'(1);
               if (pass_q == IW'(N - 1)) begin
                  state_q <= SEL;
               end
            end
            SEL: begin
               if (!skip_q) begin
                  gate_q <= selGate;
               end
               gateValid_q <= 1'b1;
               nErr_q      <= errPend_q;
`ifdef BALANCE_HOLD_EN
               hold_q      <= 1'b1;
               lastN_q     <= nOn_q;
               lastPos_q   <= iPos_q;
`endif
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mmc_sm_insertion_selector.sv
// Self-checking bench for mmc_sm_insertion_selector (N=5, W=12).
// Expected gate patterns come from a rank-counting reference: each cell's
// rank is the number of cells strictly below it (ties broken by index).
module tb_mmc_sm_insertion_selector;

   localparam int N  = 5;
   localparam int W  = 12;
   localparam int CW = $clog2(N + 1);

   logic           clk = 1'b0;
   logic           rst_n;
   logic           req_valid;
   logic           req_ready;
   logic [CW-1:0]  n_on;
   logic           i_pos;
   logic [N*W-1:0] v_cap;
   logic [N-1:0]   gate;
   logic           gate_valid;
   logic           n_err;

   int checks = 0;
   int errors = 0;

   logic [N-1:0] mGate;
   bit           mHold;
   int           mLastN;
   bit           mLastPos;

   always #5 clk = ~clk;

   mmc_sm_insertion_selector #(.N(N), .W(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .n_on       (n_on),
      .i_pos      (i_pos),
      .v_cap      (v_cap),
      .gate       (gate),
      .gate_valid (gate_valid),
      .n_err      (n_err)
   );

   // Count one comparison and report it if observed differs from expected
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Rank-based selection: insert ranks below n (charging) or at/above N-n (discharging)
   function automatic logic [N-1:0] refGate(input logic [N*W-1:0] v, input int n, input bit pos);
      logic [N-1:0] g;
      int rank;
      g = '0;
      for (int i = 0; i < N; i++) begin
         rank = 0;
         for (int j = 0; j < N; j++) begin
            if ((v[j*W +: W] < v[i*W +: W]) || ((v[j*W +: W] == v[i*W +: W]) && (j < i)))
               rank++;
         end
         g[i] = pos ? (rank < n) : (rank >= N - n);
      end
      return g;
   endfunction

   // Random voltages; with ties set, values come from a tiny set to force equal voltages
   function automatic logic [N*W-1:0] randomV(input bit ties);
      logic [N*W-1:0] v;
      for (int i = 0; i < N; i++) begin
         if (ties) v[i*W +: W] = W'($urandom_range(0, 3) * 100);
         else      v[i*W +: W] = W'($urandom);
      end
      return v;
   endfunction

   // Issue one request from mid-cycle, follow it to gate_valid and check the result
   task automatic applyStimulus(input logic [N*W-1:0] v, input int n, input bit pos, input bit scramble);
      int nc;
      bit err;
      bit hit;
      logic [N-1:0] expGate;
      int expLat;
      int cycles;
      nc  = (n > N) ? N : n;
      err = (n > N);
      hit = 1'b0;
`ifdef BALANCE_HOLD_EN
      hit = mHold && (nc == mLastN) && (pos == mLastPos);
`endif
      expGate = hit ? mGate : refGate(v, nc, pos);
      expLat  = hit ? 1 : N + 1;
      req_valid = 1'b1;
      v_cap     = v;
      n_on      = CW'(n);
      i_pos     = pos;
      checkOutput("ready_at_req", req_ready, 1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      if (scramble) begin
         v_cap = randomV(1'b0);
         n_on  = CW'($urandom_range(0, 7));
         i_pos = ~i_pos;
      end
      cycles = 0;
      do begin
         @(posedge clk);
         #1;
         cycles++;
         if (!gate_valid) begin
            checkOutput("busy_gate", gate, mGate);
            checkOutput("busy_ready", req_ready, 0);
         end
      end while (!gate_valid && cycles < 4 * N);
      checkOutput("latency", cycles, expLat);
      checkOutput("gate", gate, expGate);
      checkOutput("n_err", n_err, err);
      checkOutput("ready_in_gv", req_ready, 1);
      mGate    = expGate;
      mHold    = 1'b1;
      mLastN   = nc;
      mLastPos = pos;
   endtask

   // One idle cycle after a result: the pulse must drop and the gate must hold
   task automatic gapCycle();
      @(posedge clk);
      #1;
      checkOutput("gv_drop", gate_valid, 0);
      checkOutput("gate_keep", gate, mGate);
   endtask

   logic [N*W-1:0] v1;
   logic [N*W-1:0] vEq;
   bit             saw;

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      n_on      = '0;
      i_pos     = 1'b0;
      v_cap     = '0;
      mGate     = '0;
      mHold     = 1'b0;
      mLastN    = 0;
      mLastPos  = 1'b0;
      #2;
      checkOutput("rst_gate", gate, 0);
      checkOutput("rst_gv", gate_valid, 0);
      checkOutput("rst_nerr", n_err, 0);
      checkOutput("rst_ready", req_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      v1  = {12'd300, 12'd500, 12'd200, 12'd400, 12'd100};
      vEq = {N{12'd250}};

      applyStimulus(v1, 2, 1'b1, 1'b1);
      checkOutput("t1_gate", gate, 5'b00101);
      checkOutput("t1_err", n_err, 0);
      gapCycle();
      applyStimulus(v1, 2, 1'b0, 1'b0);
      checkOutput("t2_gate", gate, 5'b01010);
      gapCycle();
      applyStimulus(vEq, 3, 1'b1, 1'b0);
      checkOutput("t3_low", gate, 5'b00111);
      gapCycle();
      applyStimulus(vEq, 3, 1'b0, 1'b0);
      checkOutput("t3_high", gate, 5'b11100);
      gapCycle();
      applyStimulus(v1, 0, 1'b1, 1'b0);
      checkOutput("t4_zero", gate, 5'b00000);
      checkOutput("t4_zero_err", n_err, 0);
      gapCycle();
      applyStimulus(randomV(1'b0), 7, 1'b1, 1'b0);
      checkOutput("t4_over", gate, 5'b11111);
      checkOutput("t4_over_err", n_err, 1);

      applyStimulus(randomV(1'b0), 5, 1'b1, 1'b0);
      checkOutput("t6_b2b_a", gate, 5'b11111);
      checkOutput("t6_b2b_a_err", n_err, 0);
      applyStimulus(v1, 1, 1'b0, 1'b0);
      checkOutput("t6_b2b_b", gate, 5'b01000);
      gapCycle();

      req_valid = 1'b1;
      v_cap     = randomV(1'b0);
      n_on      = CW'(3);
      i_pos     = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      v_cap     = randomV(1'b0);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("t5_gate", gate, 0);
      checkOutput("t5_gv", gate_valid, 0);
      checkOutput("t5_nerr", n_err, 0);
      checkOutput("t5_ready", req_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      mGate = '0;
      mHold = 1'b0;
      saw   = 1'b0;
      repeat (N + 3) begin
         @(posedge clk);
         #1;
         saw |= gate_valid;
      end
      checkOutput("t5_nopulse", saw, 0);
      checkOutput("t5_ready_after", req_ready, 1);
      checkOutput("t5_gate_after", gate, 0);

      for (int it = 0; it < 30; it++) begin
         applyStimulus(randomV(bit'($urandom_range(0, 1))), int'($urandom_range(0, 7)),
                       bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) gapCycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Safety net in case the design stalls somewhere the bounded waits do not cover
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
